// File: rtl/aes_pkg.sv
// Shared AES definitions: GF(2^8) arithmetic, FSM states,
// and the byte-to-bit mapping of the 128-bit state.
package aes_pkg;

  localparam logic [7:0] GF_POLY = 8'h1B;
  localparam logic [7:0] IMC_E   = 8'h0E;
  localparam logic [7:0] IMC_B   = 8'h0B;
  localparam logic [7:0] IMC_D   = 8'h0D;
  localparam logic [7:0] IMC_9   = 8'h09;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  function automatic logic [7:0] xtime(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

  // Constant b folds this into a plain xtime/XOR chain.
  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic int byte_idx(
    input int r,
    input int c
  );
    return 8 * (4 * c + r);
  endfunction

endpackage

// File: rtl/inv_mix_columns_seq_if.sv
// Valid/ready bundle carrying one AES state in and one out.
// slave is the engine side, master the surrounding datapath.
interface inv_mix_columns_seq_if;

  logic         iValid;
  logic         oReady;
  logic [127:0] iData;
  logic         iBypass;
  logic         oValid;
  logic         iReady;
  logic [127:0] oData;

  modport master (
    output iValid, iData, iBypass, iReady,
    input  oReady, oValid, oData
  );

  modport slave (
    input  iValid, iData, iBypass, iReady,
    output oReady, oValid, oData
  );

endinterface

// File: rtl/inv_mix_column_word.sv
// Combinational InvMixColumns on one 32-bit column.
// Byte r of the column sits at bits [8r +: 8].
module inv_mix_column_word
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  logic [7:0] s [4];

  for (genvar r = 0; r < 4; r++) begin : g_byte
    assign s[r] = col_i[byte_idx(r, 0) +: 8];
  end

  function automatic logic [7:0] row(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] c,
    input logic [7:0] d
  );
    return gf_mul(a, IMC_E) ^ gf_mul(b, IMC_B)
         ^ gf_mul(c, IMC_D) ^ gf_mul(d, IMC_9);
  endfunction

  assign col_o[7:0]   = row(s[0], s[1], s[2], s[3]);
  assign col_o[15:8]  = row(s[1], s[2], s[3], s[0]);
  assign col_o[23:16] = row(s[2], s[3], s[0], s[1]);
  assign col_o[31:24] = row(s[3], s[0], s[1], s[2]);

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns, COLS_PER_CYCLE columns per clock,
// valid/ready in and out, bypass for the last decryption round.
module inv_mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input logic                  iClk,
  input logic                  iRst_n,
  inv_mix_columns_seq_if.slave bus
);

  localparam int NUM_STEPS = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LAST =
    2'((NUM_STEPS - 1) * COLS_PER_CYCLE);
  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 &&
      COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end

  state_e       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [127:0] data_q, data_d;
  logic         byp_q, byp_d;
  logic         rdy_q, rdy_d;
  logic         vld_q, vld_d;

  logic [1:0]  col_idx [COLS_PER_CYCLE];
  logic [31:0] col_in  [COLS_PER_CYCLE];
  logic [31:0] col_out [COLS_PER_CYCLE];

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    assign col_idx[k] = cnt_q + 2'(k);
    assign col_in[k]  = data_q[{col_idx[k], 5'd0} +: 32];
    inv_mix_column_word u_word (
      .col_i (col_in[k]),
      .col_o (col_out[k])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    byp_d   = byp_q;
    rdy_d   = rdy_q;
    vld_d   = vld_q;
    unique case (state_q)
      IDLE: begin
        rdy_d = 1'b1;
        if (bus.iValid && rdy_q) begin
          data_d  = bus.iData;
          byp_d   = bus.iBypass;
          cnt_d   = '0;
          rdy_d   = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!byp_q) begin
          for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            data_d[{col_idx[k], 5'd0} +: 32] = col_out[k];
          end
        end
        // Counter holds on the last step; IDLE re-clears it.
        if (cnt_q == LAST) begin
          vld_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + STEP;
        end
      end
      DONE: begin
        if (bus.iReady) begin
          vld_d   = 1'b0;
          rdy_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      byp_q   <= 1'b0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      byp_q   <= byp_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.oReady = rdy_q;
  assign bus.oValid = vld_q;
  assign bus.oData  = data_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Bench for inv_mix_columns_seq: three instances (1, 2, 4 columns
// per cycle) share one stimulus stream, each with its own scoreboard.
module tb_inv_mix_columns_seq;

  logic         clk;
  logic         rst_n;
  logic         valid;
  logic         byp;
  logic         rdy;
  logic [127:0] din;
  logic [127:0] exp_cur;

  logic         o_rdy  [3];
  logic         o_vld  [3];
  logic [127:0] o_data [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    inv_mix_columns_seq_if bus ();
    assign bus.iValid  = valid;
    assign bus.iData   = din;
    assign bus.iBypass = byp;
    assign bus.iReady  = rdy;
    assign o_rdy[g]  = bus.oReady;
    assign o_vld[g]  = bus.oValid;
    assign o_data[g] = bus.oData;
    inv_mix_columns_seq #(
      .COLS_PER_CYCLE (1 << g)
    ) u_dut (
      .iClk   (clk),
      .iRst_n (rst_n),
      .bus    (bus)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [127:0] q [3][$];
  int  acc_edge [3];
  bit  wait_v   [3];
  bit  rt;
  int  n_rt  [3];
  int  first [3];
  int  last  [3];

  typedef struct {
    logic [127:0] din;
    logic         byp;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward MixColumns: circulant matrix with first row 02 03 01 01.
  function automatic logic [127:0] fwd_mix(input logic [127:0] s);
    logic [7:0]   m [4];
    logic [7:0]   acc;
    logic [127:0] o;
    m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc ^= gmul(m[(k - r + 4) % 4], s[8*(4*c+k) +: 8]);
        o[8*(4*c+r) +: 8] = acc;
      end
    end
    return o;
  endfunction

  // Columns written as r0 r1 r2 r3 from the most significant byte.
  function automatic logic [127:0] st(input logic [31:0] c0,
      input logic [31:0] c1, input logic [31:0] c2,
      input logic [31:0] c3);
    logic [31:0]  w [4];
    logic [127:0] s;
    w[0] = c0; w[1] = c1; w[2] = c2; w[3] = c3;
    s = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[8*(4*c+r) +: 8] = w[c][31-8*r -: 8];
    return s;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic bit all_rdy();
    bit a = 1'b1;
    for (int g = 0; g < 3; g++) a &= (o_rdy[g] === 1'b1);
    return a;
  endfunction

  function automatic bit idle_all();
    bit a = all_rdy();
    for (int g = 0; g < 3; g++) a &= (q[g].size() == 0);
    return a;
  endfunction

  task automatic mon();
    for (int g = 0; g < 3; g++) begin
      if (!rst_n) begin
        q[g].delete();
        wait_v[g] = 1'b0;
        continue;
      end
      if (o_vld[g]) begin
        if (q[g].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_valid_d%0d: got 1 expected 0", g);
        end else begin
          if (wait_v[g]) begin
            chki($sformatf("latency_d%0d", g), cyc - acc_edge[g],
                 4 >> g);
            wait_v[g] = 1'b0;
          end
          chk($sformatf("data_d%0d", g), o_data[g], q[g][0]);
          if (rdy) void'(q[g].pop_front());
        end
      end
      if (valid && o_rdy[g]) begin
        q[g].push_back(exp_cur);
        acc_edge[g] = cyc + 1;
        wait_v[g]   = 1'b1;
        if (rt) begin
          if (n_rt[g] == 0) first[g] = cyc + 1;
          last[g] = cyc + 1;
          n_rt[g]++;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send(input logic [127:0] d, input logic b,
                      input logic [127:0] e);
    int n = 0;
    while (!all_rdy() && n < 50) begin
      tick();
      n++;
    end
    chki("send_idle_wait", int'(all_rdy()), 1);
    valid   = 1'b1;
    din     = d;
    byp     = b;
    exp_cur = e;
    tick();
    valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (!idle_all() && n < 60) begin
      tick();
      n++;
    end
    chki("drain_wait", int'(idle_all()), 1);
  endtask

  logic [127:0] orig;

  initial begin
    vecs[0] = '{st(32'h8e4da1bc, 32'h01010101, 32'h01010101,
                   32'h01010101), 1'b0,
                st(32'hdb135345, 32'h01010101, 32'h01010101,
                   32'h01010101)};
    vecs[1] = '{st(32'h9fdc589d, 32'h4d7ebdf8, 32'hd5d5d7d6,
                   32'hc6c6c6c6), 1'b0,
                st(32'hf20a225c, 32'h2d26314c, 32'hd4d4d4d5,
                   32'hc6c6c6c6)};
    vecs[2] = '{vecs[1].din, 1'b1, vecs[1].din};
    vecs[3] = '{128'h0, 1'b0, 128'h0};

    rst_n = 1'b1; valid = 1'b0; byp = 1'b0; rdy = 1'b0;
    din = '0; exp_cur = '0; rt = 1'b0;
    for (int g = 0; g < 3; g++) begin
      n_rt[g] = 0; first[g] = 0; last[g] = 0;
      acc_edge[g] = 0; wait_v[g] = 1'b0;
    end

    #2 rst_n = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      chki($sformatf("rst_ready_d%0d", g), int'(o_rdy[g]), 0);
      chki($sformatf("rst_valid_d%0d", g), int'(o_vld[g]), 0);
      chk($sformatf("rst_data_d%0d", g), o_data[g], 128'h0);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    chki("ready_before_edge", int'(o_rdy[0]), 0);
    tick();
    for (int g = 0; g < 3; g++)
      chki($sformatf("ready_after_rst_d%0d", g), int'(o_rdy[g]), 1);

    rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(vecs[i].din, vecs[i].byp, vecs[i].exp);
      drain();
      for (int g = 0; g < 3; g++)
        chk($sformatf("vec%0d_hold_d%0d", i, g), o_data[g],
            vecs[i].exp);
    end

    rdy = 1'b0;
    send(vecs[1].din, 1'b0, vecs[1].exp);
    repeat (4) tick();
    for (int j = 0; j < 10; j++) begin
      chki("bp_valid", int'(o_vld[0]), 1);
      chki("bp_ready", int'(o_rdy[0]), 0);
      if (j == 5) begin
        valid = 1'b1;
        din   = rnd128();
      end
      tick();
      valid = 1'b0;
    end
    rdy = 1'b1;
    tick();
    for (int g = 0; g < 3; g++) begin
      chki($sformatf("bp_release_valid_d%0d", g), int'(o_vld[g]), 0);
      chki($sformatf("bp_release_ready_d%0d", g), int'(o_rdy[g]), 1);
    end
    drain();

    send(vecs[1].din, 1'b0, vecs[1].exp);
    tick();
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      chki($sformatf("midrst_valid_d%0d", g), int'(o_vld[g]), 0);
      chki($sformatf("midrst_ready_d%0d", g), int'(o_rdy[g]), 0);
      chk($sformatf("midrst_data_d%0d", g), o_data[g], 128'h0);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    chki("midrst_ready_release", int'(o_rdy[0]), 0);
    tick();
    for (int g = 0; g < 3; g++)
      chki($sformatf("midrst_ready_edge_d%0d", g), int'(o_rdy[g]), 1);
    send(vecs[0].din, 1'b0, vecs[0].exp);
    drain();
    chk("after_midrst_d0", o_data[0], vecs[0].exp);

    rt = 1'b1;
    for (int n = 0; n < 8000 && n_rt[0] < 1000; n++) begin
      orig    = rnd128();
      byp     = ($urandom_range(0, 7) == 0);
      din     = byp ? orig : fwd_mix(orig);
      exp_cur = orig;
      valid   = 1'b1;
      tick();
    end
    valid = 1'b0;
    rt    = 1'b0;
    chki("rt_blocks_d0", int'(n_rt[0] >= 1000), 1);
    for (int g = 0; g < 3; g++)
      chki($sformatf("rt_spacing_d%0d", g), last[g] - first[g],
           (n_rt[g] - 1) * ((4 >> g) + 2));
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
